ecc_err_inject: RTL and testbench
=================================

ECC_ERR_INJECT -- requirements
Module: ecc_err_inject

Interface
REQ-001 K, default 8, data bits per codeword.
REQ-002 P0_LSB, default 0, overall-parity position select: 0 = P0 at codeword bit CW-1, 1 = P0 at bit 0.
REQ-003 SEED, default 16'hACE1, LFSR reset value; a value of 0 SHALL load 16'h0001.
REQ-004 clk_i  input  1  clock; all logic on rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 cw_i  input  CW  encoded codeword; CW = K + m + 1, where m is the smallest value with 2**m >= m+K+1.
REQ-007 data_i  input  K  original data, passed through unchanged for the downstream checker.
REQ-008 mode_i  input  2  0 = no flip, 1 = single flip, 2 = double flip, 3 = random 0/1/2.
REQ-009 valid_i / ready_o  input/output  1  upstream handshake.
REQ-010 cw_o  output  CW  corrupted codeword; data_o  output  K  registered data_i.
REQ-011 nflips_o, flip1_o, flip2_o  output  32 (int) each  flip count and flipped bit indices; unused index = 0.
REQ-012 valid_o / ready_i  output/input  1  downstream handshake.

Function
REQ-013 The block SHALL contain a 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle outside reset.
REQ-014 FSM states SHALL be IDLE, DRAWN, DRAW1, DRAW2, OUT; ready_o = 1 only in IDLE.
REQ-015 IDLE: on valid_i & ready_o, capture cw_i, data_i, mode_i; mode 0 -> OUT, mode 1/2 -> DRAW1 with nflips = mode, mode 3 -> DRAWN.
REQ-016 DRAWN: if LFSR[1:0] != 3, set nflips = LFSR[1:0] and go to OUT (0) or DRAW1 (1/2); otherwise stay.
REQ-017 DRAW1: with c = low PW bits of the LFSR (PW = $clog2(CW)), accept if c < CW: flip1 = c, go to OUT (nflips=1) or DRAW2 (nflips=2); otherwise stay.
REQ-018 DRAW2: accept c if c < CW and c != flip1: flip2 = c, go to OUT; otherwise stay.
REQ-019 On entry to OUT, cw_o SHALL equal captured cw XOR one-hot(flip1) (if nflips>=1) XOR one-hot(flip2) (if nflips=2); all outputs SHALL be registered and stable while in OUT.
REQ-020 OUT: valid_o = 1; on ready_i, go to IDLE. valid_o SHALL NOT drop without ready_i.
REQ-021 Minimum latency from accept to valid_o: 1 cycle (0 flips), 2 cycles (1 flip), 3 cycles (2 flips); DRAWN and rejections add 1 cycle each.
REQ-022 Flip indices SHALL be raw codeword bit indices in the range 0..CW-1, independent of P0_LSB; P0_LSB only sets p0_pos_o = (P0_LSB ? 0 : CW-1), a constant output of width 32.

Reset
REQ-023 On rst_i, the FSM SHALL go to IDLE, the LFSR SHALL load SEED, and cw_o, data_o, nflips_o, flip1_o, flip2_o and valid_o SHALL be 0, with ready_o = 1 in the cycle after reset.
REQ-024 A reset asserted mid-draw or in OUT SHALL discard the pending word without emitting it.

Configuration
REQ-025 ECC_INJ_STATS_EN defined: 32-bit saturating counters cnt0_o, cnt1_o, cnt2_o SHALL increment on each output handshake by nflips and SHALL clear on rst_i.
REQ-026 ECC_INJ_STATS_EN undefined: cnt0_o, cnt1_o and cnt2_o SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-027 Package ecc_tb_pkg SHALL hold calculate_m, the mode enum (ECC_NONE, ECC_SINGLE, ECC_DOUBLE, ECC_RANDOM), the FSM state enum and the LFSR polynomial constant.
REQ-028 Sub-module ecc_lfsr16 (parameter SEED; ports clk_i, rst_i, q_o[15:0]) SHALL implement the LFSR.

Verification (K=8, CW=13, P0_LSB=0)
REQ-029 cw_i=13'h1A5A, mode 0 -> cw_o=13'h1A5A, nflips_o=0, valid_o exactly 1 cycle after accept.
REQ-030 mode 1, 200 words -> each cw_o differs from cw_i in exactly bit flip1_o, with flip1_o <= 12 every time.
REQ-031 mode 2, 200 words -> popcount(cw_o^cw_i)=2, flip1_o != flip2_o, both indices <= 12.
REQ-032 mode 3, 1000 words -> every count 0, 1 and 2 occurs; nflips_o never 3; with ECC_INJ_STATS_EN defined, cnt0_o+cnt1_o+cnt2_o = 1000.
REQ-033 ready_i held 0 for 10 cycles in OUT -> valid_o and all outputs stable, ready_o=0; then ready_i=1 -> IDLE the next cycle.
REQ-034 rst_i pulsed while in DRAW2 -> no output, valid_o=0, ready_o=1 the next cycle, and the LFSR sequence restarts from SEED.

Source files
------------

// File: rtl/ecc_err_inject_pkg.sv
// Shared types and constants for the ECC error injector: modes, FSM states,
// LFSR feedback mask and the Hamming check-bit count helper.
package ecc_tb_pkg;

   // Right-shift Galois mask for x^16+x^14+x^13+x^11+1
   localparam logic [15:0] LFSR_POLY = 16'hB400;

   typedef enum logic [1:0] {ECC_NONE, ECC_SINGLE, ECC_DOUBLE, ECC_RANDOM} ecc_mode_e;

   typedef enum logic [2:0] {IDLE, DRAWN, DRAW1, DRAW2, OUT} inj_state_e;

   function automatic int calculate_m(input int k);
      int m;
      m = 0;
      while ((1 << m) < m + k + 1) m++;
      return m;
   endfunction

endpackage

// File: rtl/ecc_err_inject_if.sv
// Upstream/downstream codeword stream of the error injector; slave is the
// injector's view, master the driver/monitor view.
interface ecc_err_inject_if #(
   parameter int K = 8
);
   localparam int CW = K + ecc_tb_pkg::calculate_m(K) + 1;

   logic [CW-1:0] cw_i;
   logic [K-1:0]  data_i;
   logic [1:0]    mode_i;
   logic          valid_i;
   logic          ready_o;
   logic [CW-1:0] cw_o;
   logic [K-1:0]  data_o;
   int            nflips_o;
   int            flip1_o;
   int            flip2_o;
   logic          valid_o;
   logic          ready_i;

   modport slave (
      input  cw_i, data_i, mode_i, valid_i, ready_i,
      output ready_o, cw_o, data_o, nflips_o, flip1_o, flip2_o, valid_o
   );

   modport master (
      output cw_i, data_i, mode_i, valid_i, ready_i,
      input  ready_o, cw_o, data_o, nflips_o, flip1_o, flip2_o, valid_o
   );
endinterface

// File: rtl/ecc_err_inject_lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module ecc_lfsr16 import ecc_tb_pkg::*; #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [15:0] q_o
);
   localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

   always_ff @(posedge clk_i) begin
      if (rst_i) q_o <= INIT;
      else       q_o <= (q_o >> 1) ^ (q_o[0] ? LFSR_POLY : 16'h0000);
   end
endmodule

// File: rtl/ecc_err_inject.sv
// Flips 0, 1 or 2 distinct random bits of a codeword for ECC checker testing.
// ECC_INJ_STATS_EN adds saturating per-flip-count output handshake counters.
module ecc_err_inject import ecc_tb_pkg::*; #(
   parameter int          K      = 8,
   parameter int          P0_LSB = 0,
   parameter logic [15:0] SEED   = 16'hACE1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   ecc_err_inject_if.slave bus,
   output int           p0_pos_o,
   output int           cnt0_o,
   output int           cnt1_o,
   output int           cnt2_o
);
   localparam int CW = K + calculate_m(K) + 1;
   localparam int PW = $clog2(CW);

   inj_state_e    state, state_nxt;
   logic [15:0]   lfsr;
   logic [PW-1:0] c;
   logic          c_ok;
   logic [CW-1:0] c_oh;
   logic [CW-1:0] cw_q;
   logic [K-1:0]  data_q;
   logic [1:0]    nflips_q;
   logic [PW-1:0] flip1_q, flip2_q;
   logic          valid_q, ready_q;
   logic          lfsr_unused;

   ecc_lfsr16 #(.SEED(SEED)) u_lfsr (.clk_i(clk_i), .rst_i(rst_i), .q_o(lfsr));

   assign c           = lfsr[PW-1:0];
   assign c_ok        = (32'(c) < 32'(CW));
   assign c_oh        = {{(CW-1){1'b0}}, 1'b1} << c;
   assign lfsr_unused = ^lfsr[15:PW];

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (bus.valid_i) begin
                   case (bus.mode_i)
                      ECC_NONE:   state_nxt = OUT;
                      ECC_RANDOM: state_nxt = DRAWN;
                      default:    state_nxt = DRAW1;
                   endcase
                end
         DRAWN: if (lfsr[1:0] != 2'd3) state_nxt = (lfsr[1:0] == 2'd0) ? OUT : DRAW1;
         DRAW1: if (c_ok) state_nxt = (nflips_q == 2'd1) ? OUT : DRAW2;
         DRAW2: if (c_ok && (c != flip1_q)) state_nxt = OUT;
         OUT:   if (bus.ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // cw_q accumulates each accepted flip, so it is final on the edge into OUT
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cw_q     <= '0;
         data_q   <= '0;
         nflips_q <= '0;
         flip1_q  <= '0;
         flip2_q  <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         valid_q <= (state_nxt == OUT);
         ready_q <= (state_nxt == IDLE);
         case (state)
            IDLE: if (bus.valid_i) begin
                     cw_q     <= bus.cw_i;
                     data_q   <= bus.data_i;
                     flip1_q  <= '0;
                     flip2_q  <= '0;
                     nflips_q <= (bus.mode_i == ECC_RANDOM) ? 2'd0 : bus.mode_i;
                  end
            DRAWN: if (lfsr[1:0] != 2'd3) nflips_q <= lfsr[1:0];
            DRAW1: if (c_ok) begin
                      flip1_q <= c;
                      cw_q    <= cw_q ^ c_oh;
                   end
            DRAW2: if (c_ok && (c != flip1_q)) begin
                      flip2_q <= c;
                      cw_q    <= cw_q ^ c_oh;
                   end
            default: ;
         endcase
      end
   end

   assign bus.cw_o     = cw_q;
   assign bus.data_o   = data_q;
   assign bus.nflips_o = 32'(nflips_q);
   assign bus.flip1_o  = 32'(flip1_q);
   assign bus.flip2_o  = 32'(flip2_q);
   assign bus.valid_o  = valid_q;
   assign bus.ready_o  = ready_q;
   assign p0_pos_o     = (P0_LSB != 0) ? 0 : CW - 1;

`ifdef ECC_INJ_STATS_EN
   logic [2:0][31:0] cnt_q;

   for (genvar i = 0; i < 3; i++) begin : g_cnt
      always_ff @(posedge clk_i) begin
         if (rst_i)
            cnt_q[i] <= '0;
         else if (valid_q && bus.ready_i && (nflips_q == 2'(i)) && (cnt_q[i] != '1))
            cnt_q[i] <= cnt_q[i] + 32'd1;
      end
   end

   assign cnt0_o = cnt_q[0];
   assign cnt1_o = cnt_q[1];
   assign cnt2_o = cnt_q[2];
`else
   assign cnt0_o = 0;
   assign cnt1_o = 0;
   assign cnt2_o = 0;
`endif
endmodule

// File: tb/tb_ecc_err_inject.sv
// Directed bench for ecc_err_inject (K=8, CW=13, P0_LSB=0, SEED=ACE1).
module tb_ecc_err_inject;
   import ecc_tb_pkg::*;

   localparam int K  = 8;
   localparam int CW = 13;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   p0_pos, cnt0, cnt1, cnt2;
   int   n_assert = 0;
   int   n_fail   = 0;
   int   occ[3];
   int   hs_cnt;
   logic [15:0] m_lfsr;

   ecc_err_inject_if #(.K(K)) bus ();

   ecc_err_inject #(.K(K), .P0_LSB(0), .SEED(16'hACE1)) dut (
      .clk_i(clk), .rst_i(rst), .bus(bus),
      .p0_pos_o(p0_pos), .cnt0_o(cnt0), .cnt1_o(cnt1), .cnt2_o(cnt2)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lstep(input logic [15:0] q);
      return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
   endfunction

   always @(posedge clk) m_lfsr <= rst ? 16'hACE1 : lstep(m_lfsr);

   function automatic logic [CW-1:0] oh(input int i);
      logic [CW-1:0] one;
      one = 1;
      return one << i;
   endfunction

   // Expected outcome of one word given the LFSR value in the first cycle after accept
   function automatic void predict(input logic [15:0] q0, input logic [1:0] mode,
                                   output int n, output int f1, output int f2, output int lat);
      logic [15:0] q;
      q = q0; lat = 1; f1 = 0; f2 = 0; n = int'(mode);
      if (mode == 2'd3) begin
         while (q[1:0] == 2'd3) begin q = lstep(q); lat++; end
         n = int'(q[1:0]); q = lstep(q); lat++;
      end
      if (n >= 1) begin
         while (q[3:0] >= 4'd13) begin q = lstep(q); lat++; end
         f1 = int'(q[3:0]); q = lstep(q); lat++;
      end
      if (n == 2) begin
         while ((q[3:0] >= 4'd13) || (int'(q[3:0]) == f1)) begin q = lstep(q); lat++; end
         f2 = int'(q[3:0]); lat++;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [CW-1:0] cw, input logic [K-1:0] d, input logic [1:0] mode);
      int t;
      t = 0;
      while (!bus.ready_o && t < 50) begin tick(); t++; end
      chk("ready_before_send", 32'(bus.ready_o), 32'd1);
      bus.cw_i = cw; bus.data_i = d; bus.mode_i = mode; bus.valid_i = 1'b1;
      tick();
      bus.valid_i = 1'b0;
   endtask

   task automatic wait_out(output int lat);
      lat = 1;
      while (!bus.valid_o && lat < 200) begin tick(); lat++; end
      chk("valid_timeout", 32'(bus.valid_o), 32'd1);
   endtask

   // One word: send, check against prediction; leaves the bench in OUT (no handshake yet)
   task automatic xfer_nohs(input logic [CW-1:0] cw, input logic [K-1:0] d, input logic [1:0] mode,
                            output logic [CW-1:0] ecw, output int ef1);
      int n, f1, f2, lat, got;
      send(cw, d, mode);
      predict(m_lfsr, mode, n, f1, f2, lat);
      wait_out(got);
      ecw = cw ^ (n >= 1 ? oh(f1) : '0) ^ (n == 2 ? oh(f2) : '0);
      ef1 = f1;
      chk("latency", got, lat);
      chk("nflips", bus.nflips_o, n);
      chk("flip1", bus.flip1_o, f1);
      chk("flip2", bus.flip2_o, f2);
      chk("cw_o", 32'(bus.cw_o), 32'(ecw));
      chk("data_o", 32'(bus.data_o), 32'(d));
      chk("popcount", $countones(bus.cw_o ^ cw), n);
      chk("idx_range", 32'((bus.flip1_o <= 12) && (bus.flip2_o <= 12) && (bus.nflips_o <= 2)), 32'd1);
      if (n == 2) chk("distinct", 32'(bus.flip1_o != bus.flip2_o), 32'd1);
      if (n >= 0 && n <= 2) occ[n]++;
   endtask

   task automatic xfer(input logic [CW-1:0] cw, input logic [K-1:0] d, input logic [1:0] mode);
      logic [CW-1:0] ecw;
      int f1;
      xfer_nohs(cw, d, mode, ecw, f1);
      tick();
      hs_cnt++;
   endtask

   initial begin
      logic [CW-1:0] ecw;
      int f1, k;
      logic [15:0] q;
      bus.cw_i = '0; bus.data_i = '0; bus.mode_i = 2'd0; bus.valid_i = 1'b0; bus.ready_i = 1'b1;
      hs_cnt = 0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      chk("rst_valid", 32'(bus.valid_o), 32'd0);
      chk("rst_ready", 32'(bus.ready_o), 32'd1);
      chk("rst_cw", 32'(bus.cw_o), 32'd0);
      chk("rst_data", 32'(bus.data_o), 32'd0);
      chk("rst_nflips", bus.nflips_o, 32'd0);
      chk("rst_flip1", bus.flip1_o, 32'd0);
      chk("rst_flip2", bus.flip2_o, 32'd0);
      chk("p0_pos", p0_pos, 32'd12);
      chk("rst_cnt", 32'(cnt0 | cnt1 | cnt2), 32'd0);

      // pass-through, 1-cycle latency
      xfer(13'h1A5A, 8'h3C, 2'd0);
      chk("m0_cw_direct", 32'(bus.ready_o), 32'd1);

      for (int i = 0; i < 200; i++) xfer(13'($urandom), 8'($urandom), 2'd1);
      for (int i = 0; i < 200; i++) xfer(13'($urandom), 8'($urandom), 2'd2);

      // backpressure: outputs hold while ready_i is low
      bus.ready_i = 1'b0;
      xfer_nohs(13'h0F0F, 8'hA5, 2'd1, ecw, f1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", 32'(bus.valid_o), 32'd1);
         chk("bp_ready", 32'(bus.ready_o), 32'd0);
         chk("bp_cw", 32'(bus.cw_o), 32'(ecw));
         chk("bp_flip1", bus.flip1_o, f1);
         chk("bp_data", 32'(bus.data_o), 32'hA5);
      end
      bus.ready_i = 1'b1;
      tick();
      chk("bp_release_ready", 32'(bus.ready_o), 32'd1);
      chk("bp_release_valid", 32'(bus.valid_o), 32'd0);

      // reset while in DRAW2: word is dropped, LFSR restarts from SEED
      send(13'h1555, 8'h11, 2'd2);
      q = m_lfsr; k = 1;
      while (q[3:0] >= 4'd13) begin q = lstep(q); k++; end
      repeat (k) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.valid_o), 32'd0);
      chk("mid_rst_ready", 32'(bus.ready_o), 32'd1);
      chk("mid_rst_cw", 32'(bus.cw_o), 32'd0);
      chk("mid_rst_nflips", bus.nflips_o, 32'd0);
      xfer(13'h0001, 8'h22, 2'd1);

      // random mode; counters start clean after this reset
      rst = 1'b1;
      tick();
      rst = 1'b0;
      hs_cnt = 0;
      for (int i = 0; i < 3; i++) occ[i] = 0;
      for (int i = 0; i < 1000; i++) xfer(13'($urandom), 8'($urandom), 2'd3);
      chk("occ0", 32'(occ[0] > 0), 32'd1);
      chk("occ1", 32'(occ[1] > 0), 32'd1);
      chk("occ2", 32'(occ[2] > 0), 32'd1);
`ifdef ECC_INJ_STATS_EN
      chk("cnt_sum", 32'(cnt0 + cnt1 + cnt2), 32'd1000);
      chk("cnt0", cnt0, occ[0]);
      chk("cnt1", cnt1, occ[1]);
      chk("cnt2", cnt2, occ[2]);
`else
      chk("cnt0_tied", cnt0, 32'd0);
      chk("cnt1_tied", cnt1, 32'd0);
      chk("cnt2_tied", cnt2, 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
